// File: rtl/csa_chunk_collector.sv
// rtl/csa_chunk_collector.sv - assembles 4-bit adder slice beats into a WIDTH-bit sum
// Folds the previous beat's carry into each nibble and hands words out on a valid/ready port.
module csa_chunk_collector #(
    parameter int N_CHUNKS = 4,
    parameter int WIDTH    = 4 * N_CHUNKS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_sum,
    input  logic             i_cout,
    input  logic             i_valid,
    input  logic             i_first,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_cout,
    output logic             result_valid,
    input  logic             i_out_ready,
    output logic             framing_err
);

    localparam int CW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_CHUNKS - 1);

    logic [CW-1:0]    cnt;
    logic             c;
    logic [WIDTH-1:0] acc;

    logic [CW-1:0]    k;
    logic             cin;
    logic [3:0]       nib;
    logic             cnext;
    logic             is_last;
    logic             accept;
    logic             cnt_next_is_last;
    logic [WIDTH-1:0] acc_new;

    // Only a final beat can be refused; earlier beats overlap a held result.
    assign cnt_next_is_last = (N_CHUNKS == 1) || (cnt == LAST);
    assign in_ready         = ~(cnt_next_is_last & result_valid & ~i_out_ready);
    assign accept           = i_valid & in_ready;

    assign k       = i_first ? '0 : cnt;
    assign cin     = (i_first || cnt == '0) ? 1'b0 : c;
    assign nib     = i_sum + {3'b000, cin};
    assign cnext   = i_cout | (cin & (&i_sum));
    assign is_last = (k == LAST);

    always_comb begin
        acc_new = acc;
        for (int i = 0; i < N_CHUNKS; i++) begin
            if (i == int'(k)) begin
                acc_new[4*i +: 4] = nib;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            c            <= 1'b0;
            acc          <= '0;
            result       <= '0;
            result_cout  <= 1'b0;
            result_valid <= 1'b0;
            framing_err  <= 1'b0;
        end else begin
            framing_err <= accept & i_first & (cnt != '0);
            if (accept) begin
                acc <= acc_new;
                if (is_last) begin
                    cnt <= '0;
                    c   <= 1'b0;
                end else begin
                    cnt <= k + 1'b1;
                    c   <= cnext;
                end
            end
            // A completing word wins over the consumer's acceptance: no bubble.
            if (accept && is_last) begin
                result       <= acc_new;
                result_cout  <= cnext;
                result_valid <= 1'b1;
            end else if (i_out_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csa_chunk_collector.sv
// tb/tb_csa_chunk_collector.sv - scoreboard bench for csa_chunk_collector
module tb_csa_chunk_collector;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [3:0]   i_sum = '0;
    logic         i_cout = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_first = 1'b0;
    logic         in_ready;
    logic [W-1:0] result;
    logic         result_cout;
    logic         result_valid;
    logic         i_out_ready = 1'b1;
    logic         framing_err;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 0;

    logic [W:0]      sb_q[$];
    int              m_beats = 0;
    longint unsigned m_val = 0;
    bit              exp_rv = 0;
    bit              exp_ferr = 0;

    csa_chunk_collector #(.N_CHUNKS(N)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sum(i_sum), .i_cout(i_cout),
        .i_valid(i_valid), .i_first(i_first), .in_ready(in_ready),
        .result(result), .result_cout(result_cout), .result_valid(result_valid),
        .i_out_ready(i_out_ready), .framing_err(framing_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is sum_k (cout_k*16 + sum_k) * 16^k, taken mod 2^(W+1).
    always @(negedge i_clk) begin
        bit              done;
        bit              nf;
        longint unsigned term;
        if (!i_rst_n) begin
            check("rst_result", result, 0);
            check("rst_result_cout", result_cout, 0);
            check("rst_result_valid", result_valid, 0);
            check("rst_framing_err", framing_err, 0);
            sb_q.delete();
            m_beats  = 0;
            m_val    = 0;
            exp_rv   = 0;
            exp_ferr = 0;
        end else begin
            check("result_valid", result_valid, exp_rv);
            check("in_ready", in_ready, !((m_beats == N-1) && exp_rv && !i_out_ready));
            check("framing_err", framing_err, exp_ferr);
            if (exp_rv && sb_q.size() > 0) begin
                check("result", result, sb_q[0][W-1:0]);
                check("result_cout", result_cout, sb_q[0][W]);
            end
            done = 0;
            nf   = 0;
            if (i_valid && in_ready) begin
                if (i_first) begin
                    nf      = (m_beats != 0);
                    m_beats = 0;
                    m_val   = 0;
                end
                term    = {i_cout, i_sum};
                m_val   = m_val + (term << (4 * m_beats));
                m_beats = m_beats + 1;
                if (m_beats == N) begin
                    done    = 1;
                    m_beats = 0;
                    m_val   = m_val & ((64'd1 << (W+1)) - 1);
                end
            end
            if (exp_rv && i_out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (done) begin
                sb_q.push_back(m_val[W:0]);
                m_val = 0;
            end
            exp_rv   = done || (exp_rv && !i_out_ready);
            exp_ferr = nf;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
        if (rnd_rdy) i_out_ready = $urandom_range(0, 1);
    endtask

    task automatic idle(input int n);
        i_valid = 0;
        i_first = 0;
        repeat (n) step();
    endtask

    task automatic send_beat(input logic [3:0] s, input logic c, input logic f);
        bit acc;
        int t;
        i_valid = 1;
        i_sum   = s;
        i_cout  = c;
        i_first = f;
        acc = 0;
        t   = 0;
        while (!acc && t < 100) begin
            @(negedge i_clk);
            acc = in_ready;
            step();
            t++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat not accepted within 100 cycles");
        end
    endtask

    task automatic send_word(input logic [15:0] sums, input logic [3:0] couts);
        for (int k = 0; k < N; k++) send_beat(sums[4*k +: 4], couts[k], k == 0);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1;
        step();

        send_word(16'h5555, 4'b0000);
        idle(3);
        send_word(16'h0FF0, 4'b0001);
        send_word(16'hFFF0, 4'b0001);
        send_word(16'h0000, 4'b1000);
        idle(2);

        // Backpressure: A held, B's first three beats overlap, beat 3 waits.
        i_out_ready = 0;
        send_word(16'h1234, 4'b0000);
        for (int k = 0; k < 3; k++) send_beat(4'h9, 1'b0, k == 0);
        i_valid = 1; i_sum = 4'h2; i_cout = 1'b1; i_first = 0;
        repeat (3) step();
        i_out_ready = 1;
        send_beat(4'h2, 1'b1, 1'b0);
        idle(3);

        // Framing: two beats abandoned, then a fresh word.
        send_beat(4'h7, 1'b0, 1'b1);
        send_beat(4'h7, 1'b0, 1'b0);
        send_beat(4'hA, 1'b0, 1'b1);
        send_beat(4'hF, 1'b0, 1'b0);
        send_beat(4'h3, 1'b1, 1'b0);
        send_beat(4'hC, 1'b0, 1'b0);
        idle(3);

        // Asynchronous reset between edges, mid-word.
        send_beat(4'hF, 1'b1, 1'b1);
        send_beat(4'hF, 1'b0, 1'b0);
        i_valid = 0;
        #2 i_rst_n = 0;
        #1;
        check("async_result", result, 0);
        check("async_result_valid", result_valid, 0);
        check("async_in_ready", in_ready, 1);
        @(posedge i_clk);
        #2 i_rst_n = 1;
        step();
        send_beat(4'h1, 1'b0, 1'b0);
        send_beat(4'h2, 1'b0, 1'b0);
        send_beat(4'h3, 1'b0, 1'b0);
        send_beat(4'h4, 1'b0, 1'b0);
        idle(3);

        rnd_rdy = 1;
        for (int w = 0; w < 80; w++) begin
            for (int k = 0; k < N; k++) begin
                int a, b;
                bit f;
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                f = (k == 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 24) == 0);
                send_beat(4'((a + b) & 15), (a + b) > 15, f);
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            end
        end
        rnd_rdy = 0;
        i_out_ready = 1;
        idle(4);
        check("queue_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_chunk_collector.md
Name: csa_chunk_collector

Overview:
- Downstream stage of the 4-bit carry-select adder slice (no carry-in; LSB carry is tied low).
- Consumes one 4-bit sum/cout pair per beat and folds in the previous beat's carry, since the slice cannot accept one.
- Assembles N_CHUNKS beats, LSB nibble first, into a WIDTH-bit result.
- Presents the result with a valid/ready handshake so a single 4-bit slice can be time-multiplexed to build wide additions.

Parameters:
- N_CHUNKS, 4: beats per word. Legal range 1..16.
- WIDTH, 4*N_CHUNKS: result width. Derived; do not override.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous reset, active-low.
- i_sum  input  4  sum nibble from the adder slice.
- i_cout  input  1  carry-out from the adder slice.
- i_valid  input  1  i_sum/i_cout valid this cycle.
- i_first  input  1  qualifies a beat as chunk 0 of a new word.
- in_ready  output  1  collector can accept a beat this cycle.
- result  output  WIDTH  assembled sum.
- result_cout  output  1  carry-out of the full WIDTH-bit addition.
- result_valid  output  1  result/result_cout valid.
- i_out_ready  input  1  consumer accepts the result.
- framing_err  output  1  one-cycle pulse: partial word discarded.

Behaviour:
- Reset (i_rst_n low, asynchronous, at any time, including mid-word):
  - result=0, result_cout=0, result_valid=0, framing_err=0.
  - Internal chunk counter cnt=0, carry register c=0, assembly register acc=0.
- Accept: a beat is accepted when i_valid & in_ready at a rising edge.
- Per-beat arithmetic, with k = chunk index:
  - If i_first is set, k=0 and cin=0.
  - Otherwise k=cnt and cin=c (cnt=0 also gives cin=0).
  - nib = (i_sum + cin) mod 16.
  - cnext = i_cout | (cin & (i_sum==4'hF)). i_cout and that term are never both true for legal adder outputs.
  - acc[4k+3:4k] <= nib. c <= cnext.
- Word progress:
  - If k < N_CHUNKS-1: cnt <= k+1.
  - If k == N_CHUNKS-1: word completes. result <= {nib, acc[4k-1:0]}, result_cout <= cnext, result_valid <= 1, cnt <= 0, c <= 0.
- Framing:
  - i_first accepted while cnt != 0: the partial word is discarded, framing_err=1 for exactly the next cycle, and the beat is processed as chunk 0.
  - A beat at cnt==0 without i_first is a legal chunk 0; no error.
- Output handshake:
  - result_valid clears when i_out_ready is high at a rising edge, unless a new word completes in the same cycle.
  - Simultaneous completion and acceptance: result_valid stays 1 and result loads the new word. No bubble and no lost word.
  - result and result_cout are stable while result_valid & ~i_out_ready.
- in_ready = ~(cnt_next_is_last & result_valid & ~i_out_ready), where cnt_next_is_last means the next beat would be chunk N_CHUNKS-1 (cnt==N_CHUNKS-1, or N_CHUNKS==1).
  - Non-final beats are always accepted, so assembly overlaps a held result.
  - in_ready has a combinational path from i_out_ready, result_valid and cnt only; no path from i_valid.
- Latency: the result appears 1 cycle after the final beat is accepted.
  - Throughput is 1 beat/cycle when the consumer does not stall: one word per N_CHUNKS cycles.
- N_CHUNKS=1: every accepted beat completes a word, and result_cout = i_cout.
- Beats presented while in_ready=0 are not consumed. Upstream holds them.

Test Plan:
- N_CHUNKS=4, 0x1234+0x4321: beats (sum,cout) = (5,0),(5,0),(5,0),(5,0); first beat has i_first=1; i_out_ready=1 -> result=0x5555, result_cout=0, result_valid high 1 cycle, 1 cycle after the 4th beat.
- 0x0FFF+0x0001: beats (0,1),(F,0),(F,0),(0,0) -> result=0x1000, result_cout=0. Exercises carry ripple through cin & sum==F.
- 0xFFFF+0x0001: beats (0,1),(F,0),(F,0),(F,0) -> result=0x0000, result_cout=1. Then 0x8000+0x8000: (0,0),(0,0),(0,0),(0,1) -> result=0x0000, result_cout=1.
- Backpressure:
  - i_out_ready=0 with word A held; stream word B.
  - Required: beats 0-2 of B accepted, in_ready=0 at beat 3, result stays A.
  - Raise i_out_ready: in_ready goes 1 in the same cycle, B's beat 3 is accepted, and result=B the next cycle with result_valid continuously 1.
- Framing: send 2 beats, then a beat with i_first=1 followed by 3 more beats -> framing_err pulses exactly 1 cycle; the final result reflects only the last 4 beats.
- Reset mid-word: assert i_rst_n=0 asynchronously after 2 beats, between clock edges -> all outputs 0 immediately. After release, a full 4-beat word yields the correct result with no leftover carry or chunks.
